// File: rtl/tank_health_tracker_if.sv
// Hit/keycode inputs and health/match-state outputs shared between the
// tank_health_tracker and the blocks that drive and consume it.
interface tank_health_tracker_if;
  logic        shot_hit1;
  logic        shot_hit2;
  logic [31:0] keycode;
  logic [2:0]  health1;
  logic [2:0]  health2;
  logic        invuln1;
  logic        invuln2;
  logic        game_over_display;
  logic        game_over_display2;

  modport master (
    output shot_hit1, shot_hit2, keycode,
    input  health1, health2, invuln1, invuln2,
           game_over_display, game_over_display2
  );

  modport slave (
    input  shot_hit1, shot_hit2, keycode,
    output health1, health2, invuln1, invuln2,
           game_over_display, game_over_display2
  );
endinterface

// File: rtl/tank_health_tracker.sv
// Per-tank health, post-hit invulnerability and PLAY/OVER match control.
// Optional feature macro: TANK_HIT_COOLDOWN_EN (cooldown/invulnerability window).
module tank_health_tracker #(
  parameter int unsigned MAX_HEALTH      = 3,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned HOLD_FRAMES     = 180,
  parameter logic [7:0]  RESTART_KEY     = 8'h2C
) (
  input logic                  frame_clk,
  input logic                  Reset,
  tank_health_tracker_if.slave bus
);

  typedef enum logic {PLAY, OVER} state_t;

  localparam logic [2:0] HEALTH_INIT = 3'(MAX_HEALTH);
  localparam logic [9:0] HOLD_MAX    = 10'(HOLD_FRAMES);

  if (MAX_HEALTH < 1 || MAX_HEALTH > 7) begin : g_bad_max_health
    $error("MAX_HEALTH out of range 1..7");
  end
  if (COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 255) begin : g_bad_cooldown
    $error("COOLDOWN_FRAMES out of range 1..255");
  end
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 1023) begin : g_bad_hold
    $error("HOLD_FRAMES out of range 1..1023");
  end

  state_t     state;
  logic [2:0] health1, health2;
  logic [2:0] health1_next, health2_next;
  logic [9:0] hold_cnt;
  logic       go1, go2;
  logic       hit_on1, hit_on2;
  logic       restart_key, restart;

  always_comb begin
    // NOTE: default before the loop so restart_key is assigned on every path (no latch).
    restart_key = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.keycode[8*i +: 8] == RESTART_KEY) restart_key = 1'b1;
    end
  end

  assign restart = (state == OVER) && (hold_cnt == HOLD_MAX) && restart_key;

`ifdef TANK_HIT_COOLDOWN_EN
  logic [7:0] cooldown1, cooldown2;

  assign hit_on1 = bus.shot_hit2 && (cooldown1 == 8'd0);
  assign hit_on2 = bus.shot_hit1 && (cooldown2 == 8'd0);

  // Counters load on the hit edge, so invuln stays up for COOLDOWN_FRAMES edges.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cooldown1 <= 8'd0;
      cooldown2 <= 8'd0;
    end else if (state == OVER) begin
      cooldown1 <= 8'd0;
      cooldown2 <= 8'd0;
    end else begin
      if (hit_on1)                cooldown1 <= 8'(COOLDOWN_FRAMES);
      else if (cooldown1 != 8'd0) cooldown1 <= cooldown1 - 8'd1;
      if (hit_on2)                cooldown2 <= 8'(COOLDOWN_FRAMES);
      else if (cooldown2 != 8'd0) cooldown2 <= cooldown2 - 8'd1;
    end
  end

  assign bus.invuln1 = (cooldown1 != 8'd0);
  assign bus.invuln2 = (cooldown2 != 8'd0);
`else
  assign hit_on1     = bus.shot_hit2;
  assign hit_on2     = bus.shot_hit1;
  assign bus.invuln1 = 1'b0;
  assign bus.invuln2 = 1'b0;
`endif

  // Saturating decrement: a zero-health tank never wraps.
  assign health1_next = (hit_on1 && health1 != 3'd0) ? health1 - 3'd1 : health1;
  assign health2_next = (hit_on2 && health2 != 3'd0) ? health2 - 3'd1 : health2;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= PLAY;
      health1  <= HEALTH_INIT;
      health2  <= HEALTH_INIT;
      hold_cnt <= 10'd0;
      go1      <= 1'b0;
      go2      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      case (state)
        PLAY: begin
          health1  <= health1_next;
          health2  <= health2_next;
          hold_cnt <= 10'd0;
          if (health1_next == 3'd0 || health2_next == 3'd0) begin
            state <= OVER;
            go1   <= (health2_next == 3'd0);
            go2   <= (health1_next == 3'd0);
          end
        end
        OVER: begin
          if (restart) begin
            state    <= PLAY;
            health1  <= HEALTH_INIT;
            health2  <= HEALTH_INIT;
            hold_cnt <= 10'd0;
            go1      <= 1'b0;
            go2      <= 1'b0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 10'd1;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  assign bus.health1            = health1;
  assign bus.health2            = health2;
  assign bus.game_over_display  = go1;
  assign bus.game_over_display2 = go2;

endmodule

// File: doc/tank_health_tracker.md
# tank_health_tracker

Per-player health and match-state controller for the two-tank game. Consumes the one-frame hit pulses produced by the two bullet blocks and decrements the struck tank's health, with a post-hit invulnerability window. Declares game over when a tank reaches zero health. Drives `game_over_display` / `game_over_display2` back into both bullet blocks and the tank movers, and re-arms the match on a restart keypress.

## Interface
Parameters:
- `MAX_HEALTH`, default 3: starting health per tank; legal range 1..7.
- `COOLDOWN_FRAMES`, default 30: number of invulnerable frames after a hit; legal range 1..255.
- `HOLD_FRAMES`, default 180: minimum number of frames the game-over screen is held before restart is accepted; legal range 1..1023.
- `RESTART_KEY`, default 8'h2C: USB keycode (space) that restarts the match.

Ports:
- `frame_clk`  in  1: frame-rate clock, one edge per video frame.
- `Reset`  in  1: asynchronous, active-high.
- `shot_hit1`  in  1: player-1 bullet struck tank 2 this frame.
- `shot_hit2`  in  1: player-2 bullet struck tank 1 this frame.
- `keycode`  in  32: four packed USB keycode bytes.
- `health1`, `health2`  out  3: remaining health of tank 1 and tank 2.
- `invuln1`, `invuln2`  out  1: tank is in its cooldown window; used as the blink enable for the sprite.
- `game_over_display`  out  1: player 1 has won, or the match is a draw.
- `game_over_display2`  out  1: player 2 has won, or the match is a draw.

## Operation
FSM states: PLAY, OVER (no HOLD state; the hold is a counter inside OVER).

Reset behaviour (asynchronous, also applied on a restart):
- `health1` = `health2` = MAX_HEALTH.
- Cooldown counters = 0, so `invuln1` = `invuln2` = 0.
- Hold counter = 0.
- Both game-over outputs = 0.
- State = PLAY.

PLAY, evaluated every frame:
- A hit on tank 1 (`shot_hit2`=1 while `invuln1`=0):
  - health1 decrements, saturating at 0.
  - cooldown1 loads COOLDOWN_FRAMES.
- A hit on tank 2 (`shot_hit1`=1 while `invuln2`=0) behaves the same on health2 / cooldown2.
- Hits that arrive while the target is invulnerable are ignored.
- When a cooldown counter is nonzero and no new hit is taken, it decrements by 1 per frame. `invulnN` is 1 exactly when cooldownN != 0.
- Game-over decision uses the next (post-decrement) health values:
  - Only health2 next = 0: go to OVER with `game_over_display`=1.
  - Only health1 next = 0: go to OVER with `game_over_display2`=1.
  - Both = 0 in the same frame: go to OVER with both outputs = 1 (draw).
- The two tanks are processed independently in the same frame; simultaneous hits both apply.

OVER:
- Health values are frozen. Hit inputs are ignored. Cooldown counters are cleared.
- The hold counter increments each frame and saturates at HOLD_FRAMES.
- Restart condition: hold counter == HOLD_FRAMES and any one of the four keycode bytes == RESTART_KEY. When it holds, apply the reset values and return to PLAY.
- A restart key pressed before the hold elapses is ignored. It must still be held (or pressed again) after the hold to take effect.

Arithmetic:
- Health is 3-bit unsigned and never wraps below 0.
- The cooldown counter is 8 bits; the hold counter is 10 bits.

## Timing
- All outputs are registered on `posedge frame_clk`.
- A hit pulse sampled at edge N is visible on `health`/`invuln` after edge N.
- The game-over outputs assert after the same edge as the fatal decrement; the bullet blocks see them at edge N+1.
- Invulnerability lasts exactly COOLDOWN_FRAMES frames: `invuln` is high for COOLDOWN_FRAMES edges after the hit edge.
- In OVER, the earliest restart is on edge HOLD_FRAMES+1 after entry.
- Reset asserted mid-match or mid-OVER forces the reset values immediately, without waiting for a clock edge.

## Configuration
- `TANK_HIT_COOLDOWN_EN` defined: cooldown and invulnerability behave as described above.
- Not defined:
  - Cooldown counters are removed and `invuln1`/`invuln2` are tied to 0.
  - Every hit pulse decrements health, including pulses on consecutive frames.

## Test plan
- Reset, then `shot_hit1` for 1 frame -> health2=2, invuln2=1 for 30 frames then 0, health1=3, game-over outputs stay 0.
- `shot_hit1` pulses at frames 0, 10, 31 (defaults) -> health2 = 2, 2, 1; the frame-10 pulse is ignored.
- Three spaced hits on tank 2 -> after the third edge health2=0, game_over_display=1, game_over_display2=0; further hits leave health1=3.
- health1=1 and health2=1 with both hits in the same frame -> both game-over outputs = 1 (draw).
- In OVER: keycode=32'h0000002C at frame 100 -> no restart; keycode=32'h2C000000 at frame 181 -> next edge health=3/3, outputs cleared, state PLAY.
- Reset pulsed asynchronously mid-cooldown with health1=1 -> outputs return to reset values before the next frame_clk edge. With the macro undefined, hits on two consecutive frames -> health 3 -> 2 -> 1.
